// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle processor control FSM
// Moore controller; only the FETCH IRWrite/PCWrite strobes depend on an input.
module mc_ctrl_fsm #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    J_EX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;
  state_e out_state;
  logic   illegal_op_q, illegal_op_d;
  logic   mem_rdy;

  assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d      = FETCH;
    illegal_op_d = 1'b0;
    case (state_q)
      FETCH:    state_d = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_d = RTYPE_EX;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQ_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = J_EX;
          default: begin
            state_d      = FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = mem_rdy ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_rdy ? FETCH : MEMWR;
      RTYPE_EX: state_d = RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // Under reset the datapath sees FETCH controls even if the old state is still held.
  assign out_state = rst ? FETCH : state_q;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    case (out_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy & ~rst;
        PCWrite = mem_rdy & ~rst;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR, ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ADDI_WB: RegWrite = 1'b1;
      BEQ_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      J_EX: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'b0;
  logic       mem_ready = 1'b1;

  logic       pcw1, pcwc1, iord1, mrd1, mwr1, m2r1, irw1, rdst1, rw1, asa1;
  logic [1:0] asb1, pcs1, aop1;
  logic [3:0] st1;
  logic       ill1;
  logic       pcw2, pcwc2, iord2, mrd2, mwr2, m2r2, irw2, rdst2, rw2, asa2;
  logic [1:0] asb2, pcs2, aop2;
  logic [3:0] st2;
  logic       ill2;

  int checks = 0;
  int failures = 0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp}
  logic [15:0] ctl1, ctl2;
  assign ctl1 = {pcw1, pcwc1, iord1, mrd1, mwr1, m2r1, irw1, rdst1, rw1, asa1, asb1, pcs1, aop1};
  assign ctl2 = {pcw2, pcwc2, iord2, mrd2, mwr2, m2r2, irw2, rdst2, rw2, asa2, asb2, pcs2, aop2};

  mc_ctrl_fsm #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
    .MemtoReg(m2r1), .IRWrite(irw1), .RegDst(rdst1), .RegWrite(rw1), .ALUSrcA(asa1),
    .ALUSrcB(asb1), .PCSource(pcs1), .ALUOp(aop1), .state(st1), .illegal_op(ill1)
  );

  mc_ctrl_fsm #(.MEM_WAIT_EN(0)) dut_nowait (
    .clk(clk), .rst(rst), .op(op), .mem_ready(1'b0),
    .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mrd2), .MemWrite(mwr2),
    .MemtoReg(m2r2), .IRWrite(irw2), .RegDst(rdst2), .RegWrite(rw2), .ALUSrcA(asa2),
    .ALUSrcB(asb2), .PCSource(pcs2), .ALUOp(aop2), .state(st2), .illegal_op(ill2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_ready = 1'b1;
    step();
    checks++;
    if (st1 !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d want 0", st1);
    end
    checks++;
    if (ctl1 !== 16'h1010) begin
      failures++;
      $display("FAIL reset_ctl: got %h want 1010", ctl1);
    end
    checks++;
    if (ill1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_illegal: got %b want 0", ill1);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_lw;
    logic [3:0]  es[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] ec[6] = '{16'h9210, 16'h0030, 16'h0060, 16'h3000, 16'h0480, 16'h9210};
    op = 6'b100011;
    test_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (st1 !== es[i] || ctl1 !== ec[i] || ill1 !== 1'b0) begin
        failures++;
        $display("FAIL lw[%0d]: got state=%0d ctl=%h ill=%b want state=%0d ctl=%h ill=0",
                 i, st1, ctl1, ill1, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_sw_wait;
    logic [3:0]  es[8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic [15:0] ec[8] = '{16'h9210, 16'h0030, 16'h0060, 16'h2800, 16'h2800, 16'h2800, 16'h2800, 16'h9210};
    logic        mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'b101011;
    test_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      checks++;
      if (st1 !== es[i] || ctl1 !== ec[i]) begin
        failures++;
        $display("FAIL sw_wait[%0d]: got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, st1, ctl1, es[i], ec[i]);
      end
      mem_ready = mr[i];
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  es[15] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8, 4'd0,
                            4'd1, 4'd11, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    logic [15:0] ec[15] = '{16'h9210, 16'h0030, 16'h0042, 16'h0180, 16'h9210,
                            16'h0030, 16'h4045, 16'h9210, 16'h0030, 16'h8008,
                            16'h9210, 16'h0030, 16'h0060, 16'h0080, 16'h9210};
    logic [5:0]  on[15] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000100,
                            6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010,
                            6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000};
    op = 6'b000000;
    test_reset();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step();
      checks++;
      if (st1 !== es[i] || ctl1 !== ec[i] || ill1 !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d]: got state=%0d ctl=%h ill=%b want state=%0d ctl=%h ill=0",
                 i, st1, ctl1, ill1, es[i], ec[i]);
      end
      op = on[i];
    end
  endtask

  task automatic test_illegal;
    logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd0, 4'd1};
    logic [15:0] ec[4] = '{16'h9210, 16'h0030, 16'h9210, 16'h0030};
    logic        ei[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    op = 6'b111111;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (st1 !== es[i] || ctl1 !== ec[i] || ill1 !== ei[i]) begin
        failures++;
        $display("FAIL illegal[%0d]: got state=%0d ctl=%h ill=%b want state=%0d ctl=%h ill=%b",
                 i, st1, ctl1, ill1, es[i], ec[i], ei[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    op = 6'b100011;
    test_reset();
    step();
    step();
    mem_ready = 1'b0;
    step();
    step();
    checks++;
    if (st1 !== 4'd3 || ctl1 !== 16'h3000) begin
      failures++;
      $display("FAIL midrst_wait: got state=%0d ctl=%h want state=3 ctl=3000", st1, ctl1);
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl1 !== 16'h1010) begin
      failures++;
      $display("FAIL midrst_held_ctl: got %h want 1010", ctl1);
    end
    step();
    checks++;
    if (st1 !== 4'd0 || ctl1 !== 16'h1010 || ill1 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after: got state=%0d ctl=%h ill=%b want state=0 ctl=1010 ill=0",
               st1, ctl1, ill1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (st1 !== 4'd0 || ctl1 !== 16'h9210) begin
      failures++;
      $display("FAIL midrst_release: got state=%0d ctl=%h want state=0 ctl=9210", st1, ctl1);
    end
  endtask

  task automatic test_no_wait;
    logic [3:0]  es[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] ec[6] = '{16'h9210, 16'h0030, 16'h0060, 16'h3000, 16'h0480, 16'h9210};
    op = 6'b100011;
    test_reset();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (st2 !== es[i] || ctl2 !== ec[i]) begin
        failures++;
        $display("FAIL nowait[%0d]: got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, st2, ctl2, es[i], ec[i]);
      end
      checks++;
      if (st1 !== 4'd0 || ctl1 !== 16'h1010) begin
        failures++;
        $display("FAIL wait_stall[%0d]: got state=%0d ctl=%h want state=0 ctl=1010",
                 i, st1, ctl1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_illegal();
    test_reset_mid_op();
    test_no_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1; 1 = memory states wait on mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op  input  6  instruction opcode field, IR[31:26], valid from DECODE onward.
REQ-005 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite  output  1 each  datapath controls.
REQ-007 SHALL have ports ALUSrcA  output  1; ALUSrcB  output  2 (00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2); PCSource  output  2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-008 SHALL have port ALUOp  output  2  00 add, 01 subtract, 10 decode func field; drives the ALU control decoder.
REQ-009 SHALL have port state  output  4  current state code for debug.
REQ-010 SHALL have port illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-011 SHALL be a Moore FSM with states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_EX 8, ADDI_EX 9, ADDI_WB 10, J_EX 11; codes 12-15 SHALL go to FETCH next cycle.
REQ-012 SHALL transition: FETCH->DECODE when mem_ready, else stay in FETCH; DECODE by op: 000000->RTYPE_EX, 100011 or 101011->MEMADR, 000100->BEQ_EX, 001000->ADDI_EX, 000010->J_EX, other->FETCH.
REQ-013 SHALL transition: MEMADR->MEMRD if op=100011, else MEMWR; MEMRD->MEMWB when mem_ready, else stay; MEMWR->FETCH when mem_ready, else stay; MEMWB, RTYPE_WB, ADDI_WB, BEQ_EX, J_EX->FETCH; RTYPE_EX->RTYPE_WB; ADDI_EX->ADDI_WB.
REQ-014 SHALL drive in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and IRWrite=PCWrite=mem_ready (only outputs gated by an input).
REQ-015 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
REQ-016 SHALL drive in MEMADR and ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-017 SHALL drive in MEMRD: MemRead=1, IorD=1; in MEMWR: MemWrite=1, IorD=1, held every wait cycle.
REQ-018 SHALL drive in MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; in RTYPE_WB: RegWrite=1, MemtoReg=0, RegDst=1; in ADDI_WB: RegWrite=1, MemtoReg=0, RegDst=0.
REQ-019 SHALL drive in RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; in BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; in J_EX: PCWrite=1, PCSource=10.
REQ-020 SHALL drive every output not listed for a state to 0, including illegal states 12-15.
REQ-021 SHALL pulse illegal_op=1 for exactly one cycle, registered, in the cycle after DECODE with an unsupported op (coincident with FETCH).
REQ-022 SHALL, with mem_ready=1, take cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2.
REQ-023 SHALL assert MemRead and MemWrite never in the same cycle, and RegWrite never together with PCWrite.

Reset
REQ-024 SHALL on rst=1 at a rising edge set state to FETCH and illegal_op to 0, regardless of current state or mem_ready, including mid-wait in MEMRD/MEMWR.
REQ-025 SHALL, while rst=1, present FETCH Moore outputs with IRWrite=PCWrite=0 and MemWrite=0.
REQ-026 SHALL start FETCH the first cycle after rst deasserts; rst has priority over all transitions.

Verification
REQ-027 SHALL verify lw: rst then op=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-028 SHALL verify sw with wait: op=101011, mem_ready low 3 cycles in MEMWR -> state 5 held 4 cycles with MemWrite=1, then 0.
REQ-029 SHALL verify R-type/beq/j: op=000000 -> ALUOp=10 in state 6; op=000100 -> ALUOp=01, PCWriteCond=1, PCSource=01 in state 8; op=000010 -> PCWrite=1, PCSource=10 in state 11.
REQ-030 SHALL verify illegal op: op=111111 -> states 0,1,0, illegal_op=1 for one cycle, no RegWrite or MemWrite.
REQ-031 SHALL verify reset mid-operation: rst=1 during MEMRD with mem_ready=0 -> next state 0, MemWrite=0, IRWrite=0 while rst held.
REQ-032 SHALL verify MEM_WAIT_EN=0: mem_ready tied 0, op=100011 -> lw still completes in 5 cycles.
